// File: rtl/mod_counter_chain_pkg.sv
// Shared defaults and types for the modulo counter chain.
// The default configuration is a two-digit 00..59 chain.
package mod_counter_chain_pkg;

   localparam int unsigned DEF_W      = 4;
   localparam int unsigned DEF_STAGES = 2;

   // Stage 1 wraps at 5 and stage 0 wraps at 9.
   localparam logic [DEF_STAGES*DEF_W-1:0] DEF_MAX_VEC = {4'd5, 4'd9};

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

endpackage

// File: rtl/mod_counter_chain_stage.sv
// One modulo digit of the chain.
// It clamps illegal load values to zero and detects the terminal value in the current direction.
module mod_counter_stage
   import mod_counter_chain_pkg::*;
#(
   parameter int unsigned W = DEF_W
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         EN_IN,
   input  logic         UP,
   input  logic         CLR,
   input  logic         LD,
   input  logic [W-1:0] LD_VAL,
   input  logic [W-1:0] MAX,
   output logic [W-1:0] CNT,
   output logic         CARRY_OUT
);

   dir_e         dir;
   logic         term;
   logic [W-1:0] cnt_next;

   always_comb begin
      dir       = dir_e'(UP);
      term      = (dir == DIR_UP) ? (CNT == MAX) : (CNT == '0);
      // The carry depends only on the enable and the terminal value; CLR and LD do not mask it.
      CARRY_OUT = EN_IN & term;

      cnt_next = CNT;
      if (CLR) begin
         cnt_next = '0;
      end else if (LD) begin
         cnt_next = (LD_VAL > MAX) ? '0 : LD_VAL;
      end else if (EN_IN) begin
         if (dir == DIR_UP) begin
            cnt_next = term ? '0 : CNT + 1'b1;
         end else begin
            cnt_next = term ? MAX : CNT - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CNT <= '0;
      end else begin
         CNT <= cnt_next;
      end
   end

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of modulo digits.
// Each stage's carry enables the next stage, and all stages update on the same edge.
module mod_counter_chain
   import mod_counter_chain_pkg::*;
#(
   parameter int unsigned               W       = DEF_W,
   parameter int unsigned               STAGES  = DEF_STAGES,
   parameter logic [STAGES*W-1:0]       MAX_VEC = DEF_MAX_VEC
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                UP,
   input  logic                CLR,
   input  logic                LD,
   input  logic [STAGES*W-1:0] LD_VAL,
   output logic [STAGES*W-1:0] CNT,
   output logic [STAGES-1:0]   CARRY,
   output logic                TC
);

   logic [STAGES-1:0] en_chain;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_first
         assign en_chain[i] = EN;
      end else begin : g_next
         assign en_chain[i] = CARRY[i-1];
      end

      mod_counter_stage #(
         .W (W)
      ) u_stage (
         .CLK       (CLK),
         .RST       (RST),
         .EN_IN     (en_chain[i]),
         .UP        (UP),
         .CLR       (CLR),
         .LD        (LD),
         .LD_VAL    (LD_VAL[i*W +: W]),
         .MAX       (MAX_VEC[i*W +: W]),
         .CNT       (CNT[i*W +: W]),
         .CARRY_OUT (CARRY[i])
      );
   end

   assign TC = CARRY[STAGES-1];

endmodule
